// File: rtl/cmd_arg_dispatch_if.sv
// cmd_arg_dispatch_if: parser word stream plus execution-unit command/argument bus
interface cmd_arg_dispatch_if #(parameter int CMD_BITS = 5);
  logic [31:0]         in_data;
  logic                in_first;
  logic                in_valid;
  logic                in_ready;
  logic [CMD_BITS-1:0] cmd;
  logic                cmd_ready;
  logic [31:0]         arg_data;
  logic                arg_advance;
  logic                cmd_done;
  modport master (
    output in_data, in_first, in_valid, arg_advance, cmd_done,
    input  in_ready, cmd, cmd_ready, arg_data
  );
  modport slave (
    input  in_data, in_first, in_valid, arg_advance, cmd_done,
    output in_ready, cmd, cmd_ready, arg_data
  );
endinterface

// File: rtl/cmd_arg_dispatch.sv
// cmd_arg_dispatch: buffers one framed command's arguments and hands them to an execution unit
module cmd_arg_dispatch #(
  parameter int CMD_BITS = 5,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmd_arg_dispatch_if.slave    bus,
  input  logic                 err_clr,
  output logic                 framing_err,
  output logic                 underflow_err,
  output logic                 timeout_err,
  output logic                 busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, EXEC, FLUSH, DISCARD} state_t;
  state_t state, state_n, hdr_st;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] nargs, cnt, h_nargs;
  logic [TW-1:0] timer;
  logic [CMD_BITS-1:0] cmd_q;
  logic in_ready_q, cmd_ready_q;
  logic acc, hdr, too_big, push, pop, empty, full, clr_fifo, fe_set, uf_set, to_set;
  assign acc      = bus.in_valid & in_ready_q;
  assign hdr      = acc & bus.in_first;
  assign h_nargs  = bus.in_data[15:8];
  assign too_big  = {24'd0, h_nargs} > 32'(DEPTH);
  assign hdr_st   = h_nargs == 8'd0 ? ISSUE : too_big ? DISCARD : COLLECT;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = acc & ~bus.in_first & (state == COLLECT) & ~full;
  assign pop      = bus.arg_advance & (state == ISSUE || state == EXEC);
  assign clr_fifo = (hdr && state == COLLECT) || state == FLUSH;
  assign fe_set   = (hdr && (state == COLLECT || too_big)) || (acc && !bus.in_first && state == IDLE);
  assign uf_set   = pop & empty;
  // cmd_done wins over a same-cycle timeout so a unit finishing on the last allowed cycle is not flagged
  assign to_set   = TIMEOUT != 0 && state == EXEC && timer == TLAST && !bus.cmd_done;
  assign bus.in_ready  = in_ready_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.cmd       = cmd_q;
  assign bus.arg_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DISCARD: state_n = hdr ? hdr_st : state;
      COLLECT:       state_n = hdr ? hdr_st : (push && cnt + 8'd1 == nargs) ? ISSUE : COLLECT;
      ISSUE:         state_n = EXEC;
      EXEC:          state_n = (bus.cmd_done || to_set) ? FLUSH : EXEC;
      default:       state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      nargs         <= '0;
      cnt           <= '0;
      timer         <= '0;
      cmd_q         <= '0;
      in_ready_q    <= 1'b1;
      cmd_ready_q   <= 1'b0;
      busy          <= 1'b0;
      framing_err   <= 1'b0;
      underflow_err <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      in_ready_q    <= state_n inside {IDLE, COLLECT, DISCARD};
      cmd_ready_q   <= state_n == ISSUE;
      busy          <= state_n != IDLE;
      cmd_q         <= hdr ? bus.in_data[CMD_BITS-1:0] : cmd_q;
      nargs         <= hdr ? h_nargs : nargs;
      cnt           <= hdr ? 8'd0 : push ? cnt + 8'd1 : cnt;
      wr_ptr        <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr        <= clr_fifo ? wr_ptr : (pop && !empty) ? rd_ptr + 1'b1 : rd_ptr;
      timer         <= (state == ISSUE || state == EXEC) ? timer + 1'b1 : '0;
      framing_err   <= fe_set | (framing_err & ~err_clr);
      underflow_err <= uf_set | (underflow_err & ~err_clr);
      timeout_err   <= to_set | (timeout_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_cmd_arg_dispatch.sv
// tb_cmd_arg_dispatch: directed checks of framing, arg streaming, flush, errors and reset
module tb_cmd_arg_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic err_clr = 1'b0;
  logic fe, ue, te, busy;
  int total = 0;
  int bad = 0;
  cmd_arg_dispatch_if #(.CMD_BITS(5)) bus();
  cmd_arg_dispatch #(.CMD_BITS(5), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr),
    .framing_err(fe), .underflow_err(ue), .timeout_err(te), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic f, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask
  function automatic logic [31:0] hdr(input logic [4:0] c, input logic [7:0] n);
    return {16'd0, n, 3'd0, c};
  endfunction
  task automatic finish_cmd();
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    tick();
  endtask
  initial begin
    bus.in_data = '0;
    bus.in_first = 1'b0;
    bus.in_valid = 1'b0;
    bus.arg_advance = 1'b0;
    bus.cmd_done = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_arg", bus.arg_data, 0);
    chk("rst_errs", {fe, ue, te}, 0);
    rst_n = 1'b1;
    // three args streamed one per cycle
    send(1, hdr(4, 3));
    send(0, 32'h5);
    send(0, 32'h100);
    send(0, 32'h80);
    chk("t1_cmd_ready", bus.cmd_ready, 1);
    chk("t1_cmd", bus.cmd, 4);
    chk("t1_in_ready", bus.in_ready, 0);
    chk("t1_arg0", bus.arg_data, 32'h5);
    bus.arg_advance = 1'b1;
    tick();
    chk("t1_pulse", bus.cmd_ready, 0);
    chk("t1_arg1", bus.arg_data, 32'h100);
    tick();
    chk("t1_arg2", bus.arg_data, 32'h80);
    tick();
    bus.arg_advance = 1'b0;
    chk("t1_arg_empty", bus.arg_data, 0);
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    chk("t1_flush_busy", busy, 1);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_in_ready", bus.in_ready, 1);
    chk("t1_errs", {fe, ue, te}, 0);
    // partial consumption then flush
    send(1, hdr(3, 4));
    for (int i = 0; i < 4; i++) send(0, 32'hA1 + i);
    bus.arg_advance = 1'b1;
    tick();
    tick();
    bus.arg_advance = 1'b0;
    chk("t2_arg_a3", bus.arg_data, 32'hA3);
    finish_cmd();
    chk("t2_flushed", bus.arg_data, 0);
    send(1, hdr(9, 2));
    send(0, 32'hB1);
    send(0, 32'hB2);
    chk("t2_next_arg", bus.arg_data, 32'hB1);
    chk("t2_next_cmd", bus.cmd, 9);
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    tick();
    chk("t2_issue_done_ignored", busy, 1);
    chk("t2_still_b1", bus.arg_data, 32'hB1);
    finish_cmd();
    chk("t2_errs", {fe, ue, te}, 0);
    // header mid-collect
    send(1, hdr(1, 2));
    send(0, 32'hC1);
    send(1, hdr(7, 0));
    chk("t3_fe", fe, 1);
    chk("t3_cmd_ready", bus.cmd_ready, 1);
    chk("t3_cmd", bus.cmd, 7);
    chk("t3_arg_zero", bus.arg_data, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_fe_clr", fe, 0);
    finish_cmd();
    err_clr = 1'b1;
    send(0, 32'h55);
    chk("t3_set_beats_clr", fe, 1);
    tick();
    err_clr = 1'b0;
    chk("t3_fe_clr2", fe, 0);
    // oversize header, discarded args, then a full-depth command
    send(1, hdr(2, 9));
    chk("t4_fe", fe, 1);
    chk("t4_discard_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 9; i++) begin
      err_clr = (i == 0);
      send(0, 32'hD0 + i);
    end
    err_clr = 1'b0;
    chk("t4_discard_no_fe", fe, 0);
    chk("t4_discard_busy", busy, 1);
    send(1, hdr(6, 8));
    for (int i = 0; i < 8; i++) send(0, 32'hE0 + i);
    chk("t4_cmd_ready", bus.cmd_ready, 1);
    chk("t4_cmd", bus.cmd, 6);
    bus.arg_advance = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_arg%0d", i), bus.arg_data, 32'hE0 + i);
      tick();
    end
    bus.arg_advance = 1'b0;
    chk("t4_drained", bus.arg_data, 0);
    chk("t4_no_uf", ue, 0);
    finish_cmd();
    // timeout with cmd_done never asserted
    send(1, hdr(5, 0));
    chk("t5_cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("t5_no_to_yet", te, 0);
    chk("t5_busy15", busy, 1);
    tick();
    chk("t5_to", te, 1);
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_to_clr", te, 0);
    // over-popping, then reset mid-EXEC
    send(1, hdr(8, 1));
    send(0, 32'hF1);
    chk("t6_arg", bus.arg_data, 32'hF1);
    bus.arg_advance = 1'b1;
    tick();
    chk("t6_arg_zero", bus.arg_data, 0);
    chk("t6_no_uf_yet", ue, 0);
    tick();
    chk("t6_uf", ue, 1);
    tick();
    bus.arg_advance = 1'b0;
    chk("t6_uf_sticky", ue, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_in_ready", bus.in_ready, 1);
    chk("t6_rst_cmd", bus.cmd, 0);
    chk("t6_rst_arg", bus.arg_data, 0);
    chk("t6_rst_errs", {fe, ue, te}, 0);
    rst_n = 1'b1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
